// File: rtl/imm_gen_stage.sv
// RV32I/RV64I immediate + PC-relative target generator feeding a DEPTH-entry output FIFO.
// Latency 1 cycle into an empty FIFO; in_ready depends only on occupancy (never on out_ready), flush drops everything.

module imm_gen_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push;
    logic             pop;

    // A full FIFO refuses input even when the head leaves this cycle, keeping wr_rdy off the rd_rdy path.
    assign wr_rdy = (cnt_q != CNT_W'(DEPTH));
    assign rd_vld = (cnt_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign push   = wr_vld & wr_rdy & ~flush;
    assign pop    = rd_vld & rd_rdy & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_extop,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [2:0] {
        EXT_I   = 3'b000,
        EXT_U   = 3'b001,
        EXT_S   = 3'b010,
        EXT_B   = 3'b011,
        EXT_J   = 3'b100,
        EXT_Z   = 3'b101,
        EXT_SH  = 3'b110,
        EXT_RSV = 3'b111
    } extop_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  target;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    logic [63:0]     imm64;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            sgn;
    entry_t          wr_entry;
    entry_t          head;
    logic            unused_bits;

    assign sgn = in_instr[31];

    // Everything is built at 64 bits and truncated, so one table serves both XLEN values.
    always_comb begin
        imm64   = '0;
        illegal = 1'b0;
        case (extop_e'(in_extop))
            EXT_I:  imm64 = {{52{sgn}}, in_instr[31:20]};
            EXT_U:  imm64 = {{32{sgn}}, in_instr[31:12], 12'b0};
            EXT_S:  imm64 = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
            EXT_B:  imm64 = {{51{sgn}}, in_instr[31], in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            EXT_J:  imm64 = {{43{sgn}}, in_instr[31], in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            EXT_Z:  imm64 = {59'b0, in_instr[19:15]};
            EXT_SH: begin
                if (XLEN == 64) begin
                    imm64 = {58'b0, in_instr[25:20]};
                end else begin
                    imm64   = {59'b0, in_instr[24:20]};
                    illegal = in_instr[25];
                end
            end
            default: begin
                imm64   = '0;
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = imm64[XLEN-1:0];

    always_comb begin
        wr_entry         = '0;
        wr_entry.imm     = imm;
        wr_entry.target  = in_pc + imm;
        wr_entry.tag     = in_tag;
        wr_entry.illegal = illegal;
    end

    imm_gen_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (wr_entry),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head)
    );

    // Data outputs read as zero whenever no entry is presented.
    assign out_imm     = out_valid ? head.imm     : '0;
    assign out_target  = out_valid ? head.target  : '0;
    assign out_tag     = out_valid ? head.tag     : '0;
    assign out_illegal = out_valid ? head.illegal : 1'b0;

    assign unused_bits = ^{in_instr[6:0], imm64};

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_extop;
    logic [31:0] in_pc32;
    logic [63:0] in_pc64;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        r32_in_ready, r32_out_valid, r32_out_illegal;
    logic [31:0] r32_out_imm, r32_out_target;
    logic [3:0]  r32_out_tag;
    logic        r64_in_ready, r64_out_valid, r64_out_illegal;
    logic [63:0] r64_out_imm, r64_out_target;
    logic [3:0]  r64_out_tag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .DEPTH(2), .TAG_W(4)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_in_ready),
        .in_instr(in_instr), .in_extop(in_extop), .in_pc(in_pc32), .in_tag(in_tag),
        .out_valid(r32_out_valid), .out_ready(out_ready),
        .out_imm(r32_out_imm), .out_target(r32_out_target),
        .out_tag(r32_out_tag), .out_illegal(r32_out_illegal)
    );

    imm_gen_stage #(.XLEN(64), .DEPTH(2), .TAG_W(4)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_in_ready),
        .in_instr(in_instr), .in_extop(in_extop), .in_pc(in_pc64), .in_tag(in_tag),
        .out_valid(r64_out_valid), .out_ready(out_ready),
        .out_imm(r64_out_imm), .out_target(r64_out_target),
        .out_tag(r64_out_tag), .out_illegal(r64_out_illegal)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // I-format word whose immediate equals the tag, so data can be tied to its tag.
    task automatic drive(input logic v, input logic [3:0] t);
        in_valid = v;
        in_tag   = t;
        in_instr = {8'h00, t, 20'h00093};
        in_extop = 3'b000;
    endtask

    localparam int NV = 9;
    logic [31:0] v_instr [NV];
    logic [2:0]  v_op    [NV];
    logic [63:0] e32_imm [NV];
    logic [63:0] e32_tgt [NV];
    logic        e32_ill [NV];
    logic [63:0] e64_imm [NV];
    logic [63:0] e64_tgt [NV];
    logic        e64_ill [NV];

    initial begin
        //          I             U             B             J             S             Z             SH            rsvd          U(neg)
        v_instr = '{32'hFFF00093, 32'h123450B7, 32'hFE000EE3, 32'h0080006F, 32'hFE112E23, 32'h300FD073, 32'h02000093, 32'h00000013, 32'h800000B7};
        v_op    = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b010, 3'b101, 3'b110, 3'b111, 3'b001};
        e32_imm = '{64'hFFFFFFFF, 64'h12345000, 64'hFFFFFFFC, 64'h8, 64'hFFFFFFFC, 64'h1F, 64'h0, 64'h0, 64'h80000000};
        e32_tgt = '{64'hFF, 64'h12345100, 64'hFC, 64'h108, 64'hFC, 64'h11F, 64'h100, 64'h100, 64'h80000100};
        e32_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        e64_imm = '{64'hFFFFFFFFFFFFFFFF, 64'h12345000, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'hFFFFFFFFFFFFFFFC,
                    64'h1F, 64'h20, 64'h0, 64'hFFFFFFFF80000000};
        e64_tgt = '{64'hFF, 64'h12345100, 64'hFC, 64'h108, 64'hFC, 64'h11F, 64'h120, 64'h100, 64'hFFFFFFFF80000100};
        e64_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_pc32   = 32'h100;
        in_pc64   = 64'h100;
        drive(1'b0, 4'd0);
        #3;
        check_eq("rst_out_valid", r32_out_valid, 0);
        check_eq("rst_in_ready", r32_in_ready, 1);
        check_eq("rst_out_imm", r32_out_imm, 0);
        check_eq("rst_out_target", r32_out_target, 0);
        check_eq("rst_out_tag", r32_out_tag, 0);
        check_eq("rst_out_illegal", r32_out_illegal, 0);
        check_eq("rst64_out_imm", r64_out_imm, 0);

        // Format sweep: one entry per cycle, each result at the head one cycle after accept.
        in_valid = 1'b1;
        in_instr = v_instr[0];
        in_extop = v_op[0];
        in_tag   = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_instr = v_instr[i];
            in_extop = v_op[i];
            in_tag   = 4'(i);
            tick();
            check_eq($sformatf("fmt%0d_valid", i), r32_out_valid, 1);
            check_eq($sformatf("fmt%0d_tag", i), r32_out_tag, 64'(i));
            check_eq($sformatf("fmt%0d_imm32", i), r32_out_imm, e32_imm[i]);
            check_eq($sformatf("fmt%0d_tgt32", i), r32_out_target, e32_tgt[i]);
            check_eq($sformatf("fmt%0d_ill32", i), r32_out_illegal, e32_ill[i]);
            check_eq($sformatf("fmt%0d_imm64", i), r64_out_imm, e64_imm[i]);
            check_eq($sformatf("fmt%0d_tgt64", i), r64_out_target, e64_tgt[i]);
            check_eq($sformatf("fmt%0d_ill64", i), r64_out_illegal, e64_ill[i]);
        end
        drive(1'b0, 4'd0);
        tick();
        check_eq("drain_valid", r32_out_valid, 0);

        // Back-pressure: only two entries fit while the consumer stalls.
        out_ready = 1'b0;
        drive(1'b1, 4'd1);
        tick();
        check_eq("bp1_tag", r32_out_tag, 1);
        check_eq("bp1_in_ready", r32_in_ready, 1);
        drive(1'b1, 4'd2);
        tick();
        check_eq("bp2_in_ready", r32_in_ready, 0);
        check_eq("bp2_tag", r32_out_tag, 1);
        drive(1'b1, 4'd3);
        tick();
        check_eq("bp3_in_ready", r32_in_ready, 0);
        check_eq("bp3_hold_tag", r32_out_tag, 1);
        check_eq("bp3_hold_imm", r32_out_imm, 1);
        out_ready = 1'b1;
        tick();
        check_eq("bp_pop1_tag", r32_out_tag, 2);
        check_eq("bp_pop1_imm", r32_out_imm, 2);
        check_eq("bp_pop1_in_ready", r32_in_ready, 1);
        tick();
        check_eq("bp_pop2_tag", r32_out_tag, 3);
        check_eq("bp_pop2_imm", r32_out_imm, 3);
        drive(1'b1, 4'd4);
        tick();
        check_eq("bp_pop3_tag", r32_out_tag, 4);
        check_eq("bp_pop3_valid", r32_out_valid, 1);
        drive(1'b0, 4'd0);
        tick();
        check_eq("bp_empty", r32_out_valid, 0);

        // Full with a simultaneous pop: the pop happens, the offered entry waits a cycle.
        out_ready = 1'b0;
        drive(1'b1, 4'd5);
        tick();
        drive(1'b1, 4'd6);
        tick();
        check_eq("fp_full_in_ready", r32_in_ready, 0);
        out_ready = 1'b1;
        drive(1'b1, 4'd7);
        tick();
        check_eq("fp_pop_tag", r32_out_tag, 6);
        check_eq("fp_cnt", u32.u_fifo.cnt_q, 1);
        check_eq("fp_in_ready", r32_in_ready, 1);
        out_ready = 1'b0;
        tick();
        check_eq("fp_accept_in_ready", r32_in_ready, 0);
        check_eq("fp_accept_cnt", u32.u_fifo.cnt_q, 2);
        check_eq("fp_head_tag", r32_out_tag, 6);

        // Flush with two entries held and a new one offered.
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 4'd8);
        tick();
        flush = 1'b0;
        check_eq("fl_valid", r32_out_valid, 0);
        check_eq("fl_in_ready", r32_in_ready, 1);
        check_eq("fl_cnt", u32.u_fifo.cnt_q, 0);
        check_eq("fl_tag", r32_out_tag, 0);
        check_eq("fl_imm", r32_out_imm, 0);
        drive(1'b0, 4'd0);
        tick();
        check_eq("fl_dropped", r32_out_valid, 0);

        // Asynchronous reset while full.
        out_ready = 1'b0;
        drive(1'b1, 4'd9);
        tick();
        drive(1'b1, 4'd10);
        tick();
        check_eq("ar_full", r32_in_ready, 0);
        drive(1'b0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", r32_out_valid, 0);
        check_eq("ar_in_ready", r32_in_ready, 1);
        check_eq("ar_tag", r32_out_tag, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 4'd11);
        tick();
        check_eq("ar_new_valid", r32_out_valid, 1);
        check_eq("ar_new_tag", r32_out_tag, 11);
        check_eq("ar_new_imm", r32_out_imm, 11);
        drive(1'b0, 4'd0);
        tick();
        check_eq("ar_end_valid", r32_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
